// File: rtl/pull_pkg.sv
// Shared sizing helpers for the pull responder and its FIFO.
// Pointers carry one extra wrap bit above the index so full and empty
// can be told apart without a separate occupancy counter.
package pull_pkg;

   localparam int default_data_width = 32;
   localparam int default_depth      = 4;

   // Width of a read/write pointer: index bits plus the wrap bit.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Width of the occupancy report, which must represent 0..depth.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pull_fifo.sv
// Circular FIFO with wrap-bit pointers. A push while full is ignored and a
// pop while empty is ignored; the head entry is presented combinationally.
module pull_fifo
   import pull_pkg::*;
#(
   parameter int data_width = default_data_width,
   parameter int depth      = default_depth
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [data_width-1:0]         push_data,
   input  logic                          pop,
   output logic [data_width-1:0]         head,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(depth)-1:0] level
);

   localparam int ptr_w = ptr_width(depth);
   localparam int idx_w = ptr_w - 1;

   logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
   logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
   logic [data_width-1:0] mem_q [depth];
   logic [data_width-1:0] mem_d [depth];
   logic                  push_ok;
   logic                  pop_ok;

   assign full    = (wr_ptr_q[idx_w-1:0] == rd_ptr_q[idx_w-1:0]) &&
                    (wr_ptr_q[idx_w] != rd_ptr_q[idx_w]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign level   = wr_ptr_q - rd_ptr_q;
   assign head    = mem_q[rd_ptr_q[idx_w-1:0]];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   // Compute next pointers and storage; fullness is judged before any pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[idx_w-1:0]] = push_data;
         wr_ptr_d = wr_ptr_q + ptr_w'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + ptr_w'(1);
      end
   end

   // Pointer registers; reset empties the FIFO by equalising the pointers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries only become visible through the pointers.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/pull_responder.sv
// Pull responder: buffers upstream tokens and answers each downstream
// request with a single-cycle ack plus data that stays put until the next
// serve. Because ack is never high two cycles running, a requester that is
// slow to drop req cannot be served twice.
// Define PULL_RESPONDER_COUNT_EN to build the served-token counter;
// otherwise count reads constant zero and no counter flops exist.
module pull_responder
   import pull_pkg::*;
#(
   parameter int data_width = default_data_width,
   parameter int depth      = default_depth
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [data_width-1:0]         wr_data,
   output logic                          full,
   output logic [level_width(depth)-1:0] level,
   input  logic                          req,
   output logic                          ack,
   output logic [data_width-1:0]         dout,
   output logic                          overflow,
   output logic [31:0]                   count
);

   logic                  ack_q, ack_d;
   logic [data_width-1:0] dout_q, dout_d;
   logic                  overflow_q, overflow_d;
   logic [data_width-1:0] head;
   logic                  empty;
   logic                  serve;

   pull_fifo #(
      .data_width (data_width),
      .depth      (depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_en),
      .push_data (wr_data),
      .pop       (serve),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (level)
   );

   assign serve    = req && !ack_q && !empty;
   assign ack      = ack_q;
   assign dout     = dout_q;
   assign overflow = overflow_q;

   // Handshake next state: pulse ack on a serve and latch the head entry.
   always_comb begin
      ack_d      = serve;
      dout_d     = serve ? head : dout_q;
      overflow_d = overflow_q | (wr_en && full);
   end

   // Handshake registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ack_q      <= 1'b0;
         dout_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         ack_q      <= ack_d;
         dout_q     <= dout_d;
         overflow_q <= overflow_d;
      end
   end

`ifdef PULL_RESPONDER_COUNT_EN
   logic [31:0] count_q, count_d;

   // Served-token tally, wrapping naturally at 2^32.
   always_comb begin
      count_d = count_q + (serve ? 32'd1 : 32'd0);
   end

   // Counter register, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
`else
   assign count = 32'd0;
`endif

endmodule

// File: tb/tb_pull_responder.sv
// Self-checking bench for pull_responder: a queue-based model of the
// token buffer is compared against the DUT after every clock edge and on
// asynchronous reset, plus directed scenarios with literal expectations.
module tb_pull_responder;

   localparam int data_width = 32;
   localparam int depth      = 4;
   localparam int lw         = $clog2(depth) + 1;

`ifdef PULL_RESPONDER_COUNT_EN
   localparam bit count_en = 1'b1;
`else
   localparam bit count_en = 1'b0;
`endif

   logic                  clk     = 1'b0;
   logic                  rst     = 1'b0;
   logic                  wr_en   = 1'b0;
   logic [data_width-1:0] wr_data = '0;
   logic                  req     = 1'b0;
   logic                  full;
   logic [lw-1:0]         level;
   logic                  ack;
   logic [data_width-1:0] dout;
   logic                  overflow;
   logic [31:0]           count;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Reference model: token queue plus the observable handshake state.
   logic [31:0] m_q[$];
   logic        m_ack   = 1'b0;
   logic [31:0] m_dout  = '0;
   logic        m_ovf   = 1'b0;
   logic [31:0] m_count = '0;

   // Values observed on ack, with the cycle they appeared in.
   logic [31:0] got_val[$];
   int          got_cyc[$];

   pull_responder #(
      .data_width (data_width),
      .depth      (depth)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .level    (level),
      .req      (req),
      .ack      (ack),
      .dout     (dout),
      .overflow (overflow),
      .count    (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_count(input int n);
      return count_en ? 32'(n) : 32'd0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_ack   = 1'b0;
      m_dout  = '0;
      m_ovf   = 1'b0;
      m_count = '0;
   endtask

   // One clock edge of the token-buffer rules, using the inputs at the edge.
   task automatic model_step();
      bit serve;
      bit push_ok;
      serve   = (req === 1'b1) && !m_ack && (m_q.size() > 0);
      push_ok = (wr_en === 1'b1) && (m_q.size() < depth);
      if (wr_en === 1'b1 && !push_ok) m_ovf = 1'b1;
      m_ack = serve;
      if (serve) begin
         m_dout = m_q.pop_front();
         if (count_en) m_count = m_count + 32'd1;
      end
      if (push_ok) m_q.push_back(wr_data);
   endtask

   // Compare process: update the model on each edge or reset, then check.
   always begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
      #1;
      checkOutput("ack",      {31'd0, ack},      {31'd0, m_ack});
      checkOutput("dout",     dout,              m_dout);
      checkOutput("full",     {31'd0, full},     {31'd0, (m_q.size() == depth)});
      checkOutput("level",    32'(level),        32'(m_q.size()));
      checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      checkOutput("count",    count,             m_count);
      if (ack === 1'b1) begin
         got_val.push_back(dout);
         got_cyc.push_back(cyc);
      end
   end

   // Drive one cycle of inputs; returns at the following falling edge.
   task automatic applyStimulus(input logic w, input logic [31:0] d, input logic r);
      wr_en   = w;
      wr_data = d;
      req     = r;
      @(negedge clk);
   endtask

   initial begin
      int nbad;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rst_ack",   {31'd0, ack},      32'd0);
      checkOutput("rst_level", 32'(level),        32'd0);
      checkOutput("rst_full",  {31'd0, full},     32'd0);
      checkOutput("rst_dout",  dout,              32'd0);
      checkOutput("rst_count", count,             32'd0);
      rst = 1'b1;

      // Write 5,6,7 with req held: three separated acks in order
      got_val.delete(); got_cyc.delete();
      applyStimulus(1'b1, 32'd5, 1'b1);
      applyStimulus(1'b1, 32'd6, 1'b1);
      applyStimulus(1'b1, 32'd7, 1'b1);
      repeat (5) applyStimulus(1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("t1_nacks", 32'(got_val.size()), 32'd3);
      if (got_val.size() == 3) begin
         checkOutput("t1_v0", got_val[0], 32'd5);
         checkOutput("t1_v1", got_val[1], 32'd6);
         checkOutput("t1_v2", got_val[2], 32'd7);
         checkOutput("t1_gaps",
                     {31'd0, ((got_cyc[1] - got_cyc[0]) > 1) && ((got_cyc[2] - got_cyc[1]) > 1)},
                     32'd1);
      end
      checkOutput("t1_count", count, exp_count(3));

      // Fill past capacity: fifth write lost, overflow sticks
      got_val.delete(); got_cyc.delete();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 32'(i), 1'b0);
         if (i == 3) checkOutput("t2_full", {31'd0, full}, 32'd1);
      end
      checkOutput("t2_ovf",   {31'd0, overflow}, 32'd1);
      checkOutput("t2_level", 32'(level),        32'd4);
      repeat (8) applyStimulus(1'b0, 32'd0, 1'b1);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("t2_n", 32'(got_val.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_val.size(); i++)
         checkOutput("t2_val", got_val[i], 32'(i));
      checkOutput("t2_empty",  32'(level),        32'd0);
      checkOutput("t2_sticky", {31'd0, overflow}, 32'd1);

      // Request while empty: no ack until the edge after the write
      got_val.delete(); got_cyc.delete();
      repeat (10) applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t3_noack", 32'(got_val.size()), 32'd0);
      applyStimulus(1'b1, 32'd9, 1'b1);
      checkOutput("t3_nobypass", {31'd0, ack}, 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t3_ack",  {31'd0, ack}, 32'd1);
      checkOutput("t3_dout", dout,         32'd9);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("t3_count", count, exp_count(8));

      // Simultaneous write and serve at level 2
      applyStimulus(1'b1, 32'd10, 1'b0);
      applyStimulus(1'b1, 32'd11, 1'b0);
      checkOutput("t4_level_pre", 32'(level), 32'd2);
      applyStimulus(1'b1, 32'd12, 1'b1);
      checkOutput("t4_level", 32'(level),   32'd2);
      checkOutput("t4_ack",   {31'd0, ack}, 32'd1);
      checkOutput("t4_dout",  dout,         32'd10);
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("t4_level_post", 32'(level), 32'd2);

      // Asynchronous reset with level 3 and ack high
      applyStimulus(1'b1, 32'd21, 1'b0);
      applyStimulus(1'b1, 32'd22, 1'b1);
      checkOutput("t5_level_pre", 32'(level),   32'd3);
      checkOutput("t5_ack_pre",   {31'd0, ack}, 32'd1);
      wr_en = 1'b0;
      req   = 1'b0;
      #2 rst = 1'b0;
      #1;
      checkOutput("t5_ack",   {31'd0, ack},      32'd0);
      checkOutput("t5_level", 32'(level),        32'd0);
      checkOutput("t5_count", count,             32'd0);
      checkOutput("t5_dout",  dout,              32'd0);
      checkOutput("t5_ovf",   {31'd0, overflow}, 32'd0);
      wr_en   = 1'b1;
      wr_data = 32'd99;
      req     = 1'b1;
      @(negedge clk);
      @(negedge clk);
      wr_en = 1'b0;
      rst   = 1'b1;
      got_val.delete(); got_cyc.delete();
      repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);
      checkOutput("t5_stale_req", 32'(got_val.size()), 32'd0);
      applyStimulus(1'b0, 32'd0, 1'b0);

      // Stream 1000 tokens to an add-2 consumer
      got_val.delete(); got_cyc.delete();
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(1'b1, 32'(i), 1'b1);
         applyStimulus(1'b0, 32'd0, 1'b1);
         applyStimulus(1'b0, 32'd0, 1'b1);
      end
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("t6_n", 32'(got_val.size()), 32'd1000);
      nbad = 0;
      for (int i = 0; i < got_val.size(); i++)
         if (got_val[i] + 32'd2 !== 32'(i + 2)) nbad++;
      checkOutput("t6_seq_errors", 32'(nbad), 32'd0);
      if (got_val.size() == 1000) begin
         checkOutput("t6_first", got_val[0] + 32'd2,   32'd2);
         checkOutput("t6_last",  got_val[999] + 32'd2, 32'd1001);
      end
      checkOutput("t6_count", count, exp_count(1000));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pull_responder.md
PULL_RESPONDER -- requirements
Module: pull_responder

Interface
REQ-001 SHALL have parameter data_width, default 32, the token data width in bits.
REQ-002 SHALL have parameter depth, default 4, the FIFO entry count; must be a power of 2 and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1 bit: upstream push strobe.
REQ-006 SHALL have port wr_data, input, data_width bits: upstream push data.
REQ-007 SHALL have port full, output, 1 bit: FIFO holds depth entries.
REQ-008 SHALL have port level, output, $clog2(depth)+1 bits: current FIFO occupancy.
REQ-009 SHALL have port req, input, 1 bit: pull request from a downstream async_operator or consumer.
REQ-010 SHALL have port ack, output reg, 1 bit: one-cycle acknowledge pulse.
REQ-011 SHALL have port dout, output reg, data_width bits: token data, valid from ack rise.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set on a write attempted while full.
REQ-013 SHALL have port count, output, 32 bits: number of tokens served.

Function
REQ-014 SHALL store entries in a circular FIFO with read and write pointers of $clog2(depth)+1 bits; the MSB is the wrap bit.
REQ-015 SHALL define full as: pointer indices equal and wrap bits differ; empty as: pointers fully equal.
REQ-016 SHALL write wr_data at the edge where wr_en=1 and full=0.
REQ-017 SHALL drop a write when full=1 and set overflow, even if a pop occurs on the same edge; FIFO contents stay unchanged.
REQ-018 SHALL serve a request at edge k only when req=1, ack=0 and the FIFO is not empty: ack←1, dout←head entry, read pointer advances.
REQ-019 SHALL deassert ack at edge k+1; ack is never high on two consecutive cycles, so a requester that holds req one cycle after ack is never double-served.
REQ-020 SHALL hold dout constant from ack rise until the next serve, so data captured on posedge ack is stable.
REQ-021 SHALL not make a written entry eligible to serve until the edge after its write (no bypass): write at edge N, earliest ack at edge N+1.
REQ-022 SHALL perform both a write and a serve on the same edge; level is unchanged.
REQ-023 SHALL not generate ack while req=1 and the FIFO is empty; ack follows one edge after the first write.
REQ-024 SHALL report level as the write pointer minus the read pointer, modulo 2^($clog2(depth)+1).
REQ-025 SHALL increment count by 1 per serve; count wraps from 2^32-1 to 0.

Reset
REQ-026 SHALL, while rst=0, asynchronously force: pointers=0, ack=0, dout=0, overflow=0, count=0; therefore full=0 and level=0.
REQ-027 SHALL discard all FIFO entries on reset mid-operation; any pending req is served only after new writes.
REQ-028 SHALL ignore wr_en and req while in reset.

Configuration
REQ-029 SHALL compile in the count register and its increment logic when macro PULL_RESPONDER_COUNT_EN is defined.
REQ-030 SHALL, without PULL_RESPONDER_COUNT_EN, tie count to 32'd0 and instantiate no counter flops; all other behaviour is identical.

Structure
REQ-031 SHALL take pointer-width and level-width helper constants from shared package pull_pkg; no typedefs beyond these.
REQ-032 SHALL place storage and pointers in one sub-module, pull_fifo (push/pop/full/empty/level); handshake and count logic stay in pull_responder.

Verification
REQ-033 SHALL cover: reset, then write 5,6,7 with req held 1 → acks on 3 separate non-adjacent cycles, dout=5,6,7 in order, count=3.
REQ-034 SHALL cover: depth=4, write 0..4 with req=0 → full=1 after the 4th write, overflow=1, 5th value lost; then pulling 4 tokens yields 0,1,2,3.
REQ-035 SHALL cover: req=1 with the FIFO empty for 10 cycles → ack stays 0; write 9 at edge N → ack=1 after edge N+1, dout=9.
REQ-036 SHALL cover: level=2 with simultaneous wr_en and serve → level stays 2 and the write is accepted.
REQ-037 SHALL cover: rst pulsed low with level=3 and ack high → ack, level, count and dout all read 0 immediately, without waiting for a clock edge.
REQ-038 SHALL cover: chain to an async_operator "addi" immediate=2 and pull 1000 tokens 0..999 → outputs 2..1001 in order, count=1000.
